periph_uart_tx: RTL and testbench

PERIPH_UART_TX -- requirements
Module: periph_uart_tx

---
 rtl/periph_pkg.sv | 23 ++
 rtl/fifo_sync.sv | 52 +++++
 rtl/periph_uart_tx.sv | 146 ++++++++++++++
 tb/tb_periph_uart_tx.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/periph_pkg.sv
// Shared constants and types for the UART transmit peripheral.
// Register map offsets, STATUS bit positions and FSM states.
package periph_pkg;

  localparam logic [31:0] UART_BASE_ADR = 32'h0000_2000;

  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;

  localparam int ST_BUSY    = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_EMPTY   = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 4;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

endpackage

// File: rtl/fifo_sync.sv
// Single-clock FIFO with a separate occupancy count.
// Push while full succeeds only when a pop happens in the same cycle.
module fifo_sync #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int NW    = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [NW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = count == NW'(DEPTH);
  assign empty   = count == '0;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + NW'(1);
        2'b01:   count <= count - NW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/periph_uart_tx.sv
// Memory-mapped UART transmitter: TXDATA/STATUS registers, byte FIFO, 8N1 framer.
// tx_o is registered from the current state, so the line lags the FSM by one cycle.
module periph_uart_tx
  import periph_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 10_000_000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [31:0] BASE_ADR    = UART_BASE_ADR
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        mem_write_i,
  input  logic [31:0] data_adr_i,
  input  logic [31:0] write_data_i,
  output logic [31:0] read_data_o,
  output logic        tx_o
);

  localparam int unsigned DIV = (CLK_FREQ_HZ + BAUD / 2) / BAUD;
  localparam int          CW  = $clog2(DIV + 1);
  localparam int          NW  = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

  uart_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          tx_q, tx_d;
  logic          ovf_q, ovf_d;

  logic          hit;
  logic [1:0]    off;
  logic          wr_tx;
  logic          wr_st;
  logic          pop;
  logic [7:0]    head;
  logic          full;
  logic          empty;
  logic [NW-1:0] fifo_cnt;
  logic [31:0]   status;
  logic          unused;

  assign hit    = data_adr_i[31:4] == BASE_ADR[31:4];
  assign off    = data_adr_i[3:2];
  assign wr_tx  = mem_write_i && hit && off == OFF_TXDATA;
  assign wr_st  = mem_write_i && hit && off == OFF_STATUS;
  assign unused = ^{data_adr_i[1:0], write_data_i[31:8]};

  fifo_sync #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push    (wr_tx),
    .pop     (pop),
    .din     (write_data_i[7:0]),
    .dout    (head),
    .full    (full),
    .empty   (empty),
    .count   (fifo_cnt)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    tx_d    = 1'b1;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shreg_d = head;
          cnt_d   = RELOAD;
          state_d = START;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (cnt_q == '0) begin
          cnt_d   = RELOAD;
          idx_d   = 3'd0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DATA: begin
        tx_d = shreg_q[idx_q];
        if (cnt_q == '0) begin
          cnt_d = RELOAD;
          if (idx_q == 3'd7) state_d = STOP;
          else idx_d = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      STOP: begin
        if (cnt_q == '0) state_d = IDLE;
        else cnt_d = cnt_q - CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // A dropped byte in the same cycle as a clear leaves OVF set.
  always_comb begin
    ovf_d = ovf_q;
    if (wr_st && write_data_i[ST_OVF]) ovf_d = 1'b0;
    if (wr_tx && full && !pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    status                     = '0;
    status[ST_BUSY]            = state_q != IDLE;
    status[ST_FULL]            = full;
    status[ST_EMPTY]           = empty;
    status[ST_OVF]             = ovf_q;
    status[ST_CNT_LSB +: 4]    = 4'(fifo_cnt);
  end

  assign read_data_o = (hit && off == OFF_STATUS) ? status : 32'h0;
  assign tx_o        = tx_q;

endmodule

// File: tb/tb_periph_uart_tx.sv
// Self-checking bench for periph_uart_tx against a frame-timing reference model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_periph_uart_tx;

  localparam int DIV   = 87;
  localparam int FRAME = 10 * DIV;
  localparam int GAP   = FRAME + 1;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] adr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        tx;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  periph_uart_tx dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .mem_write_i  (mem_write),
    .data_adr_i   (adr),
    .write_data_i (wdata),
    .read_data_o  (rdata),
    .tx_o         (tx)
  );

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    mem_write = 1'b1;
    adr       = a;
    wdata     = d;
    @(negedge clk);
    mem_write = 1'b0;
    adr       = 32'h2004;
    wdata     = 32'h0;
    #1;
  endtask

  task automatic test_reset();
    mem_write = 1'b0;
    adr       = 32'h2004;
    reset     = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (tx !== 1'b1) begin
      fails++;
      $display("FAIL reset_tx got %b want 1", tx);
    end
    checks++;
    if (rdata !== 32'h4) begin
      fails++;
      $display("FAIL reset_status got %h want 00000004", rdata);
    end
    reset = 1'b0;
    @(negedge clk);
    adr = 32'h2000;
    #1;
    checks++;
    if (rdata !== 32'h0) begin
      fails++;
      $display("FAIL reset_txdata_rd got %h want 00000000", rdata);
    end
    adr = 32'h2004;
    @(negedge clk);
  endtask

  // Stores n bytes on consecutive edges 0..n-1, then checks every cycle.
  // Frame f starts on the line at edge 2 + f*GAP; its pop is one edge earlier.
  task automatic run_stream(input string name, input int n, input int fixed);
    logic [7:0]  b [$];
    int          s [$];
    int          last;
    int          j;
    int          slot;
    int          stored;
    int          popped;
    int          cnt;
    logic        exp_tx;
    logic        exp_busy;
    logic [31:0] exp_st;
    for (int f = 0; f < n; f++) begin
      b.push_back(fixed >= 0 ? 8'(fixed) : 8'($urandom));
      s.push_back(2 + f * GAP);
    end
    last = s[n-1] + FRAME + 4;
    for (int k = 0; k <= last; k++) begin
      if (k > 0) begin
        j        = k - 1;
        exp_tx   = 1'b1;
        exp_busy = 1'b0;
        popped   = 0;
        for (int f = 0; f < n; f++) begin
          if (j >= s[f] && j < s[f] + FRAME) begin
            slot = (j - s[f]) / DIV;
            if (slot == 0) exp_tx = 1'b0;
            else if (slot == 9) exp_tx = 1'b1;
            else exp_tx = b[f][slot-1];
          end
          if (j >= s[f] - 1 && j <= s[f] + FRAME - 2) exp_busy = 1'b1;
          if (j >= s[f] - 1) popped++;
        end
        stored = (j + 1 < n) ? j + 1 : n;
        cnt    = stored - popped;
        exp_st = {24'h0, 4'(cnt), 1'b0, cnt == 0, cnt == DEPTH, exp_busy};
        if (adr != 32'h2004) exp_st = 32'h0;
        checks++;
        if (tx !== exp_tx) begin
          fails++;
          $display("FAIL %s_tx cycle %0d got %b want %b", name, j, tx, exp_tx);
        end
        checks++;
        if (rdata !== exp_st) begin
          fails++;
          $display("FAIL %s_status cycle %0d got %h want %h",
                   name, j, rdata, exp_st);
        end
      end
      if (k < n) begin
        mem_write = 1'b1;
        adr       = 32'h2000;
        wdata     = {24'($urandom), b[k]};
      end else begin
        mem_write = 1'b0;
        adr       = 32'h2004;
        wdata     = 32'h0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 9; i++) begin
      mem_write = 1'b1;
      adr       = 32'h2000;
      wdata     = $urandom;
      @(negedge clk);
    end
    mem_write = 1'b0;
    adr       = 32'h2004;
    #1;
    checks++;
    if (rdata !== 32'h83) begin
      fails++;
      $display("FAIL ovf_full9 got %h want 00000083", rdata);
    end
    store(32'h2000, $urandom);
    checks++;
    if (rdata !== 32'h8B) begin
      fails++;
      $display("FAIL ovf_set got %h want 0000008b", rdata);
    end
    store(32'h2004, 32'hFFFF_FFF7);
    checks++;
    if (rdata !== 32'h8B) begin
      fails++;
      $display("FAIL ovf_hold got %h want 0000008b", rdata);
    end
    store(32'h2004, 32'h8);
    checks++;
    if (rdata !== 32'h83) begin
      fails++;
      $display("FAIL ovf_clear got %h want 00000083", rdata);
    end
    store(32'h2000, $urandom);
    checks++;
    if (rdata !== 32'h8B) begin
      fails++;
      $display("FAIL ovf_reset got %h want 0000008b", rdata);
    end
  endtask

  task automatic test_reset_mid_frame();
    mem_write = 1'b1;
    adr       = 32'h2000;
    wdata     = 32'h0;
    @(negedge clk);
    wdata     = 32'hA5;
    @(negedge clk);
    mem_write = 1'b0;
    adr       = 32'h2004;
    repeat (299) @(negedge clk);
    checks++;
    if (tx !== 1'b0) begin
      fails++;
      $display("FAIL mid_tx_before got %b want 0", tx);
    end
    checks++;
    if (rdata !== 32'h11) begin
      fails++;
      $display("FAIL mid_status_before got %h want 00000011", rdata);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (tx !== 1'b1) begin
      fails++;
      $display("FAIL mid_tx_after got %b want 1", tx);
    end
    checks++;
    if (rdata !== 32'h4) begin
      fails++;
      $display("FAIL mid_status_after got %h want 00000004", rdata);
    end
    for (int i = 0; i < 2 * GAP; i += 16) begin
      repeat (16) @(negedge clk);
      checks++;
      if (tx !== 1'b1 || rdata !== 32'h4) begin
        fails++;
        $display("FAIL mid_quiet cycle %0d got tx=%b st=%h want tx=1 st=00000004",
                 i, tx, rdata);
      end
    end
  endtask

  task automatic test_no_hit();
    logic [31:0] addrs [6];
    logic [31:0] want;
    addrs = '{32'h0000_0010, 32'h0000_2008, 32'h0000_200C,
              32'h0000_3000, 32'h0000_1FFC, 32'h0000_2004};
    for (int i = 0; i < 6; i++) begin
      mem_write = 1'b1;
      adr       = addrs[i];
      wdata     = {$urandom} | 32'h55;
      #1;
      want = (addrs[i] == 32'h2004) ? 32'h4 : 32'h0;
      checks++;
      if (rdata !== want) begin
        fails++;
        $display("FAIL nohit_rd adr %h got %h want %h", addrs[i], rdata, want);
      end
      @(negedge clk);
      mem_write = 1'b0;
      adr       = 32'h2004;
      repeat (3) @(negedge clk);
      checks++;
      if (rdata !== 32'h4 || tx !== 1'b1) begin
        fails++;
        $display("FAIL nohit_state adr %h got st=%h tx=%b want st=00000004 tx=1",
                 addrs[i], rdata, tx);
      end
    end
  endtask

  initial begin
    test_reset();
    run_stream("frame55", 1, 8'h55);
    run_stream("b2b", 4, -1);
    run_stream("single", 1, -1);
    test_overflow();
    test_reset();
    test_reset_mid_frame();
    test_reset();
    test_no_hit();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
